chan_scan_mux: RTL

//  - Parametrised N-channel source selector for the board display path; generalises the two-way

---
 rtl/chan_scan_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/chan_scan_mux.sv
// rtl/chan_scan_mux.sv - N-channel display source selector with manual select, auto-scan and freeze
//
// Picks one of NUM_CH WIDTH-bit sources for the display path. In manual mode the
// sel input chooses the channel. In auto-scan mode the selector moves to the next
// enabled channel every DWELL clocks. A freeze input holds the current output.
// result and cur_ch are registered and always describe the same channel.
//
// Optional feature: define CHAN_SCAN_CHG_PULSE_EN to add the ch_chg output.
//
// Ports:
//   clk        in   1             system clock, rising edge
//   rst        in   1             asynchronous active-low reset
//   ch_data    in   NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   valid_mask in   NUM_CH        1 = channel k may be selected/scanned
//   mode       in   1             0 = manual, 1 = auto-scan
//   sel        in   SEL_W         requested channel in manual mode
//   freeze     in   1             1 = hold result, cur_ch and dwell count
//   result     out  WIDTH         registered data of the selected channel (0 if disabled)
//   cur_ch     out  SEL_W         channel currently driving result
//   ch_chg     out  1             (CHAN_SCAN_CHG_PULSE_EN only) one-clock pulse when cur_ch changes
module chan_scan_mux #(
  parameter int WIDTH  = 3,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       valid_mask,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    freeze,
  output logic [WIDTH-1:0]        result,
`ifdef CHAN_SCAN_CHG_PULSE_EN
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    ch_chg
`else
  output logic [SEL_W-1:0]        cur_ch
`endif
);

  localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SLOTS  = 2 ** SEL_W;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   NUM_CH_L   = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [SEL_W-1:0] next_ch;
  logic [SEL_W-1:0] scan_ch, cand;
  logic             scan_hit;

  // Channel data and mask widened to the full sel range so any SEL_W-bit index
  // is legal; slots beyond NUM_CH read as disabled / zero.
  logic [SLOTS-1:0] mask_ext;
  logic [WIDTH-1:0] data_arr [SLOTS];

  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_CH-1:0] = valid_mask;
    for (int k = 0; k < SLOTS; k++) begin
      data_arr[k] = '0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      data_arr[k] = ch_data[k*WIDTH +: WIDTH];
    end
  end

  // Freeze takes priority over mode in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_MANUAL: begin
        if (freeze)    state_nxt = ST_HOLD;
        else if (mode) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (freeze)     state_nxt = ST_HOLD;
        else if (!mode) state_nxt = ST_MANUAL;
      end
      ST_HOLD: begin
        if (!freeze) state_nxt = mode ? ST_SCAN : ST_MANUAL;
      end
      default: state_nxt = ST_MANUAL;
    endcase
  end

  // Round-robin search for the next enabled channel after cur_ch, wrapping at
  // NUM_CH-1. cur_ch itself is not visited, so with nothing else enabled we stay.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = cur_ch;
    cand     = cur_ch;
    for (int i = 1; i < NUM_CH; i++) begin
      cand = (cand == LAST_CH) ? '0 : cand + SEL_W'(1);
      if (!scan_hit && mask_ext[cand]) begin
        scan_hit = 1'b1;
        scan_ch  = cand;
      end
    end
  end

  always_comb begin
    next_ch   = cur_ch;
    dwell_nxt = dwell_cnt;
    case (state)
      ST_MANUAL: begin
        if (({1'b0, sel} < NUM_CH_L) && mask_ext[sel]) next_ch = sel;
        // Entering scan restarts the dwell period from the held channel.
        if (!freeze && mode) dwell_nxt = '0;
      end
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (scan_hit) next_ch = scan_ch;
        end else begin
          dwell_nxt = dwell_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_MANUAL;
      dwell_cnt <= '0;
      cur_ch    <= '0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      // In HOLD the output must not follow live ch_data, so skip the update.
      if (state != ST_HOLD) begin
        cur_ch <= next_ch;
        result <= mask_ext[next_ch] ? data_arr[next_ch] : '0;
      end
    end
  end

`ifdef CHAN_SCAN_CHG_PULSE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_chg <= 1'b0;
    end else begin
      ch_chg <= (state != ST_HOLD) && (next_ch != cur_ch);
    end
  end
`endif

endmodule
